lcd_bus_receiver: RTL

Synthesizable responder for the 8-bit HD44780-style LCD bus (`en`, `rs`, `rw`, `data`) that our LCD writer drives. It samples each bus transaction on the falling edge of `en`, decodes commands and character writes, maintains a 32-character two-line display buffer and cursor address, and answers busy-flag and data reads. It sits on the far side of the LCD bus. It is used as an on-chip display mirror and as the checker model in writer benches.

---
 rtl/lcd_bus_if.sv | 12 +
 rtl/lcd_bus_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_if.sv
// 8-bit HD44780-style LCD bus between the writer (master) and a responder (slave).
interface lcd_bus_if;
    logic       en;
    logic       rs;
    logic       rw;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (output en, rs, rw, data_in, input  data_out, data_oe);
    modport slave  (input  en, rs, rw, data_in, output data_out, data_oe);
endinterface

// File: rtl/lcd_bus_receiver.sv
// LCD bus responder: samples transactions on the falling edge of en, keeps a
// 2x16 character mirror plus cursor, and answers busy-flag and data reads.
//
// state   | meaning
// S_READY | idle, next valid transaction is executed
// S_BUSY  | executing; transactions other than busy-flag reads set overrun
module lcd_bus_receiver #(
    parameter int unsigned BUSY_CYCLES       = 2000,
    parameter int unsigned CLEAR_BUSY_CYCLES = 76000,
    parameter int unsigned MIN_EN_CYCLES     = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    lcd_bus_if.slave   bus,
    output logic       busy_o,
    output logic [6:0] cursor_o,
    output logic       cmd_valid_o,
    output logic [7:0] cmd_byte_o,
    output logic       char_valid_o,
    output logic [7:0] char_byte_o,
    input  logic [4:0] rd_addr_i,
    output logic [7:0] rd_char_o,
    output logic       overrun_o
);
    localparam int unsigned MAX_BUSY = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
    localparam int unsigned CW       = $clog2(MAX_BUSY + 1);
    localparam int unsigned HW       = $clog2(MIN_EN_CYCLES + 1);
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_BUSY_CYCLES - 1);
    localparam logic [HW-1:0] HI_MIN     = HW'(MIN_EN_CYCLES - 1);
    localparam logic [HW-1:0] HI_SAT     = HW'(MIN_EN_CYCLES);

    typedef enum logic {S_READY, S_BUSY} state_e;
    typedef enum logic {M_DDRAM, M_CGRAM} mode_e;

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      cursor_q, cursor_d;
    logic            id_q, id_d;
    logic [31:0][7:0] cells_q, cells_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [7:0]      cmd_byte_q, cmd_byte_d;
    logic            char_valid_q, char_valid_d;
    logic [7:0]      char_byte_q, char_byte_d;
    logic            overrun_q, overrun_d;

    logic [2:0]      en_sync_q, rs_sync_q, rw_sync_q;
    logic [7:0]      data_s1_q, data_s2_q, data_s3_q;
    logic [HW-1:0]   hi_cnt_q;

    logic            fall, valid_fall, bf_read, cur_vis, load;
    logic [4:0]      cur_idx;
    logic [7:0]      cur_cell;
    logic [CW-1:0]   load_val;

    // Linear walk over 0x00-0x27 and 0x40-0x67; strays snap to the adjacent row.
    function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        r = a;
        if (inc) begin
            if (a >= 7'h27 && a < 7'h40) r = 7'h40;
            else if (a >= 7'h67)         r = 7'h00;
            else                         r = a + 7'd1;
        end else begin
            if (a == 7'h00)                  r = 7'h67;
            else if (a >= 7'h28 && a <= 7'h40) r = 7'h27;
            else if (a > 7'h67)              r = 7'h67;
            else                             r = a - 7'd1;
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_sync_q <= '0;
            rs_sync_q <= '0;
            rw_sync_q <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
            data_s3_q <= '0;
            hi_cnt_q  <= '0;
        end else begin
            en_sync_q <= {en_sync_q[1:0], bus.en};
            rs_sync_q <= {rs_sync_q[1:0], bus.rs};
            rw_sync_q <= {rw_sync_q[1:0], bus.rw};
            data_s1_q <= bus.data_in;
            data_s2_q <= data_s1_q;
            data_s3_q <= data_s2_q;
            if (!en_sync_q[2])         hi_cnt_q <= '0;
            else if (hi_cnt_q != HI_SAT) hi_cnt_q <= hi_cnt_q + HW'(1);
        end
    end

    assign fall       = en_sync_q[2] & ~en_sync_q[1];
    assign valid_fall = fall && (hi_cnt_q >= HI_MIN);
    assign bf_read    = ~rs_sync_q[2] & rw_sync_q[2];

    // Visible cells: 0x00-0x0F -> 0..15, 0x40-0x4F -> 16..31.
    assign cur_vis  = (cursor_q[6:4] == 3'b000) || (cursor_q[6:4] == 3'b100);
    assign cur_idx  = {cursor_q[6], cursor_q[3:0]};
    assign cur_cell = cur_vis ? cells_q[cur_idx] : 8'h20;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        cursor_d     = cursor_q;
        id_d         = id_q;
        cells_d      = cells_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        char_valid_d = 1'b0;
        char_byte_d  = char_byte_q;
        overrun_d    = overrun_q;
        load         = 1'b0;
        load_val     = BUSY_LOAD;

        case (state_q)
            S_READY: ;
            S_BUSY: begin
                if (cnt_q == '0) state_d = S_READY;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_READY;
        endcase

        if (valid_fall && !bf_read) begin
            if (state_q == S_BUSY) begin
                overrun_d = 1'b1;
            end else begin
                case ({rs_sync_q[2], rw_sync_q[2]})
                    2'b00: begin
                        cmd_valid_d = 1'b1;
                        cmd_byte_d  = data_s3_q;
                        load        = 1'b1;
                        casez (data_s3_q)
                            8'b1???????: begin
                                cursor_d = data_s3_q[6:0];
                                mode_d   = M_DDRAM;
                            end
                            8'b01??????: mode_d = M_CGRAM;
                            8'b000001??: id_d   = data_s3_q[1];
                            8'b0000001?: begin
                                cursor_d = 7'h00;
                                mode_d   = M_DDRAM;
                                load_val = CLEAR_LOAD;
                            end
                            8'b00000001: begin
                                cells_d  = {32{8'h20}};
                                cursor_d = 7'h00;
                                id_d     = 1'b1;
                                mode_d   = M_DDRAM;
                                load_val = CLEAR_LOAD;
                            end
                            8'b00000000: load = 1'b0;
                            default: ;
                        endcase
                    end
                    2'b10: begin
                        load = 1'b1;
                        if (mode_q == M_DDRAM) begin
                            if (cur_vis) begin
                                cells_d[cur_idx] = data_s3_q;
                                char_valid_d     = 1'b1;
                                char_byte_d      = data_s3_q;
                            end
                            cursor_d = next_addr(cursor_q, id_q);
                        end
                    end
                    2'b11: begin
                        load = 1'b1;
                        if (mode_q == M_DDRAM) cursor_d = next_addr(cursor_q, id_q);
                    end
                    default: ;
                endcase
            end
        end

        if (load) begin
            state_d = S_BUSY;
            cnt_d   = load_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_READY;
            mode_q       <= M_DDRAM;
            cnt_q        <= '0;
            cursor_q     <= '0;
            id_q         <= 1'b1;
            cells_q      <= {32{8'h20}};
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
            char_valid_q <= 1'b0;
            char_byte_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            cursor_q     <= cursor_d;
            id_q         <= id_d;
            cells_q      <= cells_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            char_valid_q <= char_valid_d;
            char_byte_q  <= char_byte_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.data_oe  = en_sync_q[1] & rw_sync_q[1];
    assign bus.data_out = !bus.data_oe  ? 8'h00 :
                          rs_sync_q[1]  ? cur_cell : {busy_o, cursor_q};

    assign busy_o       = (state_q == S_BUSY);
    assign cursor_o     = cursor_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_byte_o   = cmd_byte_q;
    assign char_valid_o = char_valid_q;
    assign char_byte_o  = char_byte_q;
    assign rd_char_o    = cells_q[rd_addr_i];
    assign overrun_o    = overrun_q;
endmodule
